// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring monitor: ring width,
// FSM state encoding, error codes and 7-segment glyphs.
package ring_pkg;

  localparam int NBITS_RING = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } ring_state_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_SKIP       = 2'b10;

  // Segment order is bit0=a .. bit6=g; the decimal point is added by the top.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/ring_monitor_seg7_decode.sv
// Combinational BCD-to-7-segment decoder; an error request overrides the
// digit and shows 'E'. Non-BCD codes blank the display.
module seg7_decode
  import ring_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       err,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    if (err) begin
      segments = SEG_E;
    end else begin
      case (bcd)
        4'd0:    segments = SEG_0;
        4'd1:    segments = SEG_1;
        4'd2:    segments = SEG_2;
        4'd3:    segments = SEG_3;
        4'd4:    segments = SEG_4;
        4'd5:    segments = SEG_5;
        4'd6:    segments = SEG_6;
        4'd7:    segments = SEG_7;
        4'd8:    segments = SEG_8;
        4'd9:    segments = SEG_9;
        default: segments = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ring_monitor.sv
// Watches an upstream one-hot ring counter, counts completed laps in BCD,
// flags sequence errors (sticky) and drives a 7-segment lap display.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int NBITS_RING = ring_pkg::NBITS_RING
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NBITS_RING-1:0] count_in,
  output logic [3:0]            lap_count,
  output logic                  lap_pulse,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [7:0]            seg,
  output ring_state_t           state_dbg
);

  localparam logic [NBITS_RING-1:0] RING_FIRST  = NBITS_RING'(1);
  localparam logic [NBITS_RING-1:0] RING_SECOND = NBITS_RING'(2);

  ring_state_t           r_state;
  logic [NBITS_RING-1:0] r_expected;
  logic [3:0]            r_lap;
  logic                  r_pulse;
  logic                  r_err;
  logic [1:0]            r_code;

  logic                  w_onehot;
  logic [NBITS_RING-1:0] w_rotl;
  logic [3:0]            w_lap_inc;
  logic [6:0]            w_seg7;

  assign w_onehot  = (count_in != '0) && ((count_in & (count_in - RING_FIRST)) == '0);
  assign w_rotl    = {r_expected[NBITS_RING-2:0], r_expected[NBITS_RING-1]};
  assign w_lap_inc = (r_lap == 4'd9) ? 4'd0 : r_lap + 4'd1;

  // Handshake-free monitor: count_in is sampled unconditionally every edge,
  // and every output reflects the value seen on the previous edge.
  always_ff @(posedge clk_2) begin
    if (reset || clear) begin
      r_state    <= IDLE;
      r_expected <= RING_SECOND;
      r_lap      <= 4'd0;
      r_pulse    <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= ERR_NONE;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (count_in == RING_FIRST) begin
            r_state    <= TRACK;
            r_expected <= RING_SECOND;
          end
        end
        TRACK: begin
          if (count_in == r_expected) begin
            // Wrapping back to the first position closes a lap.
            if (r_expected == RING_FIRST) begin
              r_lap   <= w_lap_inc;
              r_pulse <= 1'b1;
            end
            r_expected <= w_rotl;
          end else if (count_in == RING_FIRST) begin
            r_expected <= RING_SECOND;
          end else if (count_in == '0) begin
            r_state <= IDLE;
          end else if (!w_onehot) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
            r_code  <= ERR_NOT_ONEHOT;
          end else begin
            r_state <= ERROR;
            r_err   <= 1'b1;
            r_code  <= ERR_SKIP;
          end
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Display is a pure decode of registered state, so it moves in step with lap_count.
  seg7_decode u_seg7 (
    .bcd      (r_lap),
    .err      (r_err),
    .segments (w_seg7)
  );

  assign lap_count = r_lap;
  assign lap_pulse = r_pulse;
  assign err       = r_err;
  assign err_code  = r_code;
  assign seg       = {(r_state == TRACK), w_seg7};
  assign state_dbg = r_state;

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: a behavioural reference model pushes
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_ring_monitor;
  import ring_pkg::*;

  localparam int W = 18;

  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  count_in = 4'd0;
  logic [3:0]  lap_count;
  logic        lap_pulse;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  seg;
  ring_state_t state_dbg;

  ring_monitor #(.NBITS_RING(4)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .clear     (clear),
    .count_in  (count_in),
    .lap_count (lap_count),
    .lap_pulse (lap_pulse),
    .err       (err),
    .err_code  (err_code),
    .seg       (seg),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: position index of the expected bit rather than a one-hot register
  logic [1:0] m_state;
  int         m_pos;
  int         m_lap;
  logic       m_pulse;
  logic       m_err;
  logic [1:0] m_code;

  function automatic logic [6:0] digit_seg(int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic clr, input logic [3:0] cin);
    logic [3:0] exp_oh;
    logic [7:0] m_seg;
    m_pulse = 1'b0;
    if (rst || clr) begin
      m_state = 2'd0; m_pos = 1; m_lap = 0; m_err = 1'b0; m_code = 2'b00;
    end else if (m_state == 2'd0) begin
      if (cin == 4'b0001) begin m_state = 2'd1; m_pos = 1; end
    end else if (m_state == 2'd1) begin
      exp_oh = 4'(1 << m_pos);
      if (cin == exp_oh) begin
        if (m_pos == 0) begin
          m_lap = (m_lap + 1) % 10;
          m_pulse = 1'b1;
        end
        m_pos = (m_pos + 1) % 4;
      end else if (cin == 4'b0001) begin
        m_pos = 1;
      end else if (cin == 4'b0000) begin
        m_state = 2'd0;
      end else if ($countones(cin) > 1) begin
        m_state = 2'd2; m_err = 1'b1; m_code = 2'b01;
      end else begin
        m_state = 2'd2; m_err = 1'b1; m_code = 2'b10;
      end
    end
    m_seg = m_err ? 8'h79 : {(m_state == 2'd1), digit_seg(m_lap)};
    exp_q.push_back({m_state, 4'(m_lap), m_pulse, m_err, m_code, m_seg});
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("state",     state_dbg, e[17:16]);
      check_val("lap_count", lap_count, e[15:12]);
      check_val("lap_pulse", lap_pulse, e[11]);
      check_val("err",       err,       e[10]);
      check_val("err_code",  err_code,  e[9:8]);
      check_val("seg",       seg,       e[7:0]);
    end
    if (lap_pulse) pulse_count++;
  endtask

  // Driver
  task automatic drive(input logic rst, input logic clr, input logic [3:0] cin);
    @(negedge clk_2);
    reset = rst; clear = clr; count_in = cin;
    model_step(rst, clr, cin);
    @(posedge clk_2);
    #1;
    compare_out();
  endtask

  task automatic ring(input logic [3:0] cin);
    drive(1'b0, 1'b0, cin);
  endtask

  initial begin
    int p0;
    int r;
    logic [3:0] v;

    // Reset state
    drive(1'b1, 1'b0, 4'b0000);
    check_val("rst_seg", seg, 8'h3F);

    // Basic lap
    ring(4'b0001);
    check_val("enter_track", state_dbg, TRACK);
    ring(4'b0010); ring(4'b0100); ring(4'b1000); ring(4'b0001);
    check_val("lap1_pulse", lap_pulse, 1'b1);
    check_val("lap1_count", lap_count, 4'd1);
    check_val("lap1_seg", seg, 8'h86);
    ring(4'b0010);
    check_val("pulse_one_cycle", lap_pulse, 1'b0);

    // Ten laps wrap 9 -> 0
    drive(1'b1, 1'b0, 4'b0000);
    ring(4'b0001);
    p0 = pulse_count;
    for (int l = 0; l < 10; l++) begin
      ring(4'b0010); ring(4'b0100); ring(4'b1000); ring(4'b0001);
    end
    check_val("wrap_count", lap_count, 4'd0);
    check_val("wrap_seg", seg, 8'hBF);
    check_val("wrap_pulses", pulse_count - p0, 10);

    // Not one-hot while expecting 0100, error is sticky
    ring(4'b0010);
    ring(4'b0110);
    check_val("noh_code", err_code, 2'b01);
    check_val("noh_seg", seg, 8'h79);
    ring(4'b0001); ring(4'b0010);
    check_val("noh_sticky", state_dbg, ERROR);

    // Skipped step, then clear
    drive(1'b0, 1'b1, 4'b0000);
    ring(4'b0001);
    ring(4'b1000);
    check_val("skip_code", err_code, 2'b10);
    drive(1'b0, 1'b1, 4'b0000);
    check_val("clr_state", state_dbg, IDLE);
    check_val("clr_seg", seg, 8'h3F);

    // Upstream load resync and upstream reset
    ring(4'b0001); ring(4'b0010); ring(4'b0100); ring(4'b1000); ring(4'b0001);
    ring(4'b0010);
    ring(4'b0001);
    check_val("resync_pulse", lap_pulse, 1'b0);
    ring(4'b0010);
    check_val("resync_track", state_dbg, TRACK);
    ring(4'b0000);
    check_val("idle_lap_held", lap_count, 4'd1);

    // Reset and clear together in ERROR
    ring(4'b0001); ring(4'b0100);
    drive(1'b1, 1'b1, 4'b0000);
    check_val("rstclr_err", err, 1'b0);

    // Random traffic, biased toward legal ring progress
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      end else if (r < 5) begin
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      end else begin
        if (r < 72) v = (m_state == 2'd1) ? 4'(1 << m_pos) : 4'b0001;
        else if (r < 80) v = 4'b0001;
        else if (r < 85) v = 4'b0000;
        else v = 4'($urandom_range(0, 15));
        ring(v);
      end
    end

    check_val("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
